// File: rtl/hcsr04_medidor_param.sv
// hcsr04_medidor_param: HC-SR04 trigger/echo controller measuring echo width in rounded centimetres with retry and periodic mode.
module hcsr04_medidor_param #(
  parameter int TRIG_CYCLES    = 500,
  parameter int CM_CYCLES      = 2941,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int MAX_RETRY      = 3,
  parameter int HOLDOFF_CYCLES = 3000000,
  parameter int DIST_W         = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              medir,
  input  logic              continuo,
  input  logic              echo,
  output logic              trigger,
  output logic [DIST_W-1:0] distancia,
  output logic              pronto,
  output logic              erro,
  output logic              ocupado,
  output logic [3:0]        db_estado
);
  localparam int TW = $clog2(TRIG_CYCLES);
  localparam int OW = $clog2(TIMEOUT_CYCLES);
  localparam int SW = $clog2(CM_CYCLES);
  localparam int HW = $clog2(HOLDOFF_CYCLES);
  localparam int RW = $clog2(MAX_RETRY + 2);
  typedef enum logic [3:0] {
    INICIAL       = 4'd0,
    PREPARACAO    = 4'd1,
    ENVIA_TRIGGER = 4'd2,
    ESPERA_ECHO   = 4'd3,
    MEDIDA        = 4'd4,
    ARMAZENAMENTO = 4'd5,
    FINAL         = 4'd6,
    ERRO          = 4'd7,
    HOLDOFF       = 4'd8
  } estado_t;
  estado_t state, next;
  logic e1, echo_s;
  logic [TW-1:0] trig_cnt;
  logic [OW-1:0] to_cnt;
  logic [SW-1:0] sub_cnt;
  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] retry;
  logic [DIST_W-1:0] cm_cnt;
  logic [DIST_W:0] rounded;
  logic timeout, counting;
  assign timeout  = to_cnt == OW'(TIMEOUT_CYCLES - 1);
  // The cycle in which ESPERA_ECHO first sees echo_s high is counted too, so width is exact
  assign counting = echo_s && (state == ESPERA_ECHO || state == MEDIDA);
  assign rounded  = {1'b0, cm_cnt} + (DIST_W+1)'(sub_cnt >= SW'(CM_CYCLES / 2));
  assign pronto    = state == FINAL;
  assign ocupado   = state != INICIAL;
  assign db_estado = state > HOLDOFF ? 4'hE : state;
  always_comb begin
    next = state;
    case (state)
      INICIAL:       next = medir ? PREPARACAO : INICIAL;
      PREPARACAO:    next = ENVIA_TRIGGER;
      ENVIA_TRIGGER: next = trig_cnt == TW'(TRIG_CYCLES - 1) ? ESPERA_ECHO : ENVIA_TRIGGER;
      ESPERA_ECHO:   next = echo_s ? MEDIDA : !timeout ? ESPERA_ECHO :
                            retry < RW'(MAX_RETRY) ? PREPARACAO : ERRO;
      MEDIDA:        next = !echo_s ? ARMAZENAMENTO : timeout ? ERRO : MEDIDA;
      ARMAZENAMENTO: next = FINAL;
      FINAL, ERRO:   next = continuo ? HOLDOFF : INICIAL;
      HOLDOFF:       next = !continuo ? INICIAL :
                            hold_cnt == HW'(HOLDOFF_CYCLES - 1) ? PREPARACAO : HOLDOFF;
      default:       next = INICIAL;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= INICIAL;
      e1        <= 1'b0;
      echo_s    <= 1'b0;
      trigger   <= 1'b0;
      trig_cnt  <= '0;
      to_cnt    <= '0;
      sub_cnt   <= '0;
      cm_cnt    <= '0;
      hold_cnt  <= '0;
      retry     <= '0;
      distancia <= '0;
      erro      <= 1'b0;
    end else begin
      state    <= next;
      e1       <= echo;
      echo_s   <= e1;
      trigger  <= next == ENVIA_TRIGGER;
      trig_cnt <= state == ENVIA_TRIGGER ? trig_cnt + 1'b1 : '0;
      to_cnt   <= (state == ESPERA_ECHO && !echo_s) || state == MEDIDA ? to_cnt + 1'b1 : '0;
      hold_cnt <= state == HOLDOFF ? hold_cnt + 1'b1 : '0;
      if (state == PREPARACAO) begin
        sub_cnt <= '0;
        cm_cnt  <= '0;
      end else if (counting) begin
        sub_cnt <= sub_cnt == SW'(CM_CYCLES - 1) ? '0 : sub_cnt + 1'b1;
        if (sub_cnt == SW'(CM_CYCLES - 1) && cm_cnt != '1) cm_cnt <= cm_cnt + 1'b1;
      end
      if (state == INICIAL || state == HOLDOFF) retry <= '0;
      else if (state == ESPERA_ECHO && !echo_s && timeout && retry < RW'(MAX_RETRY))
        retry <= retry + 1'b1;
      if (state == ARMAZENAMENTO) begin
        distancia <= rounded[DIST_W] ? '1 : rounded[DIST_W-1:0];
        erro      <= 1'b0;
      end else if (state == ERRO) erro <= 1'b1;
    end
  end
endmodule
